// File: rtl/pb_pkg.sv
// Shared types, default parameters and width helper for the push-button conditioner.
// Auto-repeat logic is built only when PB_AUTOREPEAT_EN is defined.
package pb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rep_state_e;

    localparam int PB_N_BTN     = 5;
    localparam int PB_TICK_DIV  = 65536;
    localparam int PB_DB_TICKS  = 4;
    localparam int PB_REP_DELAY = 64;
    localparam int PB_REP_RATE  = 16;

    // Bits needed to hold the values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pb_channel.sv
// One button channel: tick-sampled debounce, level and press-pulse registers,
// plus the auto-repeat FSM when PB_AUTOREPEAT_EN is defined.
module pb_channel
    import pb_pkg::*;
#(
    parameter int DB_TICKS  = PB_DB_TICKS,
    parameter int REP_DELAY = PB_REP_DELAY,
    parameter int REP_RATE  = PB_REP_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic s,
    output logic level,
    output logic pulse,
    output logic pulse_set
);

    localparam int DB_W = cnt_width(DB_TICKS);

    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            level_d;
    logic            rise;

    // NOTE: every output of a combinational block gets a default first; a
    // path that leaves one unassigned would infer a latch.
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level;
        if (tick) begin
            if (s != level) begin
                if (db_cnt_q == DB_W'(DB_TICKS)) begin
                    level_d  = ~level;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_d = '0;
            end
        end
    end

    assign rise = level_d & ~level;

`ifdef PB_AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int REP_W   = cnt_width(REP_MAX);

    rep_state_e       state_q;
    rep_state_e       state_d;
    logic [REP_W-1:0] rep_cnt_q;
    logic [REP_W-1:0] rep_cnt_d;
    logic [REP_W-1:0] rep_inc;
    logic             fall;
    logic             rep_pulse;

    assign fall    = level & ~level_d;
    assign rep_inc = (rep_cnt_q == REP_W'(REP_MAX)) ? rep_cnt_q : rep_cnt_q + 1'b1;

    // A release always wins over a repeat due on the same tick.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        rep_pulse = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = HOLD;
                    rep_cnt_d = '0;
                end
            end
            HOLD: begin
                if (fall) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else if (tick) begin
                    if (rep_inc >= REP_W'(REP_DELAY)) begin
                        state_d   = REPEAT;
                        rep_cnt_d = '0;
                        rep_pulse = 1'b1;
                    end else begin
                        rep_cnt_d = rep_inc;
                    end
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else if (tick) begin
                    if (rep_inc >= REP_W'(REP_RATE)) begin
                        rep_cnt_d = '0;
                        rep_pulse = 1'b1;
                    end else begin
                        rep_cnt_d = rep_inc;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                rep_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign pulse_set = rise | rep_pulse;
`else
    // Repeat parameters stay on the port list so both builds instantiate alike.
    logic unused_rep_cfg;
    assign unused_rep_cfg = (REP_DELAY > 0) ^ (REP_RATE > 0);
    assign pulse_set      = rise;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q <= '0;
            level    <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level    <= level_d;
            pulse    <= pulse_set;
        end
    end

endmodule

// File: rtl/pb_conditioner.sv
// Multi-channel push-button conditioner: synchronisers, shared sample tick,
// per-channel debounce/pulse, registered pb_any. Optional repeat: PB_AUTOREPEAT_EN.
module pb_conditioner
    import pb_pkg::*;
#(
    parameter int N_BTN     = PB_N_BTN,
    parameter int TICK_DIV  = PB_TICK_DIV,
    parameter int DB_TICKS  = PB_DB_TICKS,
    parameter int REP_DELAY = PB_REP_DELAY,
    parameter int REP_RATE  = PB_REP_RATE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] pb_raw,
    output logic [N_BTN-1:0] pb_level,
    output logic [N_BTN-1:0] pb_pulse,
    output logic             pb_any,
    output logic             tick
);

    localparam int TICK_W = cnt_width(TICK_DIV - 1);

    logic [N_BTN-1:0]  sync_q;
    logic [N_BTN-1:0]  s;
    logic [N_BTN-1:0]  pulse_set;
    logic [TICK_W-1:0] tick_cnt;

    // Two-flop synchroniser per button; pb_raw is asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s      <= '0;
        end else begin
            sync_q <= pb_raw;
            s      <= sync_q;
        end
    end

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        pb_channel #(
            .DB_TICKS  (DB_TICKS),
            .REP_DELAY (REP_DELAY),
            .REP_RATE  (REP_RATE)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .s         (s[i]),
            .level     (pb_level[i]),
            .pulse     (pb_pulse[i]),
            .pulse_set (pulse_set[i])
        );
    end

    // Built from the same next-state terms as pb_pulse so the two stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pb_any <= 1'b0;
        end else begin
            pb_any <= |pulse_set;
        end
    end

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed self-checking bench for pb_conditioner (TICK_DIV=4, DB_TICKS=3,
// REP_DELAY=5, REP_RATE=2); repeat checks only when PB_AUTOREPEAT_EN is defined.
module tb_pb_conditioner;
    import pb_pkg::*;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pb_raw;
    logic [N-1:0] pb_level;
    logic [N-1:0] pb_pulse;
    logic         pb_any;
    logic         tick;

    int tests = 0;
    int fails = 0;
    int pulse_count [N] = '{default: 0};
    logic [N-1:0] prev_pulse = '0;

    pb_conditioner #(
        .N_BTN     (N),
        .TICK_DIV  (4),
        .DB_TICKS  (3),
        .REP_DELAY (5),
        .REP_RATE  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pb_raw   (pb_raw),
        .pb_level (pb_level),
        .pb_pulse (pb_pulse),
        .pb_any   (pb_any),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        tests++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pulse(input int ch, input int limit, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (pb_pulse[ch] !== 1'b1 && lat < limit);
        if (pb_pulse[ch] !== 1'b1) lat = -1;
    endtask

    task automatic wait_level(input int ch, input logic val, input int limit, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (pb_level[ch] !== val && lat < limit);
        if (pb_level[ch] !== val) lat = -1;
    endtask

    // Continuous monitor: pb_any tracks pb_pulse, pulses last one cycle.
    always @(negedge clk) begin
        check("any_align", {31'b0, pb_any}, {31'b0, |pb_pulse});
        check("pulse_width", {27'b0, pb_pulse & prev_pulse}, 32'd0);
        for (int i = 0; i < N; i++) begin
            if (pb_pulse[i] === 1'b1) pulse_count[i]++;
        end
        prev_pulse = pb_pulse;
    end

    initial begin
        int lat;
        int gap;
        int cnt_snap;

        rst    = 1'b1;
        pb_raw = '0;
        step(3);
        check("rst_level", {27'b0, pb_level}, 32'd0);
        check("rst_pulse", {27'b0, pb_pulse}, 32'd0);
        check("rst_any", {31'b0, pb_any}, 32'd0);
        check("rst_tick", {31'b0, tick}, 32'd0);

        rst = 1'b0;
        step(3);
        check("tick_first", {31'b0, tick}, 32'd1);
        step(1);
        check("tick_low", {31'b0, tick}, 32'd0);
        step(3);
        check("tick_period", {31'b0, tick}, 32'd1);

        // Clean press on channel 0.
        pb_raw[0] = 1'b1;
        wait_pulse(0, 40, lat);
        check_range("press0_lat", lat, 14, 18);
        check("press0_level", {31'b0, pb_level[0]}, 32'd1);
        check("press0_pulse", {27'b0, pb_pulse}, 32'h01);
        check("press0_any", {31'b0, pb_any}, 32'd1);
        step(1);
        check("press0_pulse_end", {31'b0, pb_pulse[0]}, 32'd0);
        check("press0_any_end", {31'b0, pb_any}, 32'd0);
        step(100 - lat - 1);
`ifndef PB_AUTOREPEAT_EN
        check("press0_single", pulse_count[0], 32'd1);
`endif

        // Release channel 0: level falls, no pulse on the fall.
        pb_raw[0] = 1'b0;
        wait_level(0, 1'b0, 40, lat);
        check_range("release0_lat", lat, 14, 18);
        check("release0_no_pulse", {31'b0, pb_pulse[0]}, 32'd0);
        cnt_snap = pulse_count[0];
        step(40);
        check("release0_quiet", pulse_count[0], cnt_snap);

        // Bouncing channel 1: toggles every 5 cycles for 40 cycles, then held.
        for (int k = 0; k < 8; k++) begin
            pb_raw[1] = (k % 2 == 0);
            step(5);
        end
        check("bounce_no_pulse", pulse_count[1], 32'd0);
        check("bounce_level", {31'b0, pb_level[1]}, 32'd0);
        pb_raw[1] = 1'b1;
        wait_pulse(1, 40, lat);
        check_range("bounce_lat", lat, 14, 18);
        step(10);
        check("bounce_one_pulse", pulse_count[1], 32'd1);
        pb_raw[1] = 1'b0;
        wait_level(1, 1'b0, 40, lat);
        check_range("bounce_release_lat", lat, 14, 18);

        // Simultaneous presses on channels 2 and 3.
        pb_raw[3:2] = 2'b11;
        wait_pulse(2, 40, lat);
        check_range("simul_lat", lat, 14, 18);
        check("simul_pulse", {27'b0, pb_pulse}, 32'h0C);
        check("simul_any", {31'b0, pb_any}, 32'd1);
        step(1);
        check("simul_pulse_end", {27'b0, pb_pulse}, 32'd0);
        check("simul_any_end", {31'b0, pb_any}, 32'd0);
        pb_raw[3:2] = 2'b00;
        wait_level(2, 1'b0, 40, lat);
        check_range("simul_release_lat", lat, 14, 18);
        check("simul_release_lvl3", {31'b0, pb_level[3]}, 32'd0);

        // Reset while channel 0 is pressed and accepted.
        pb_raw[0] = 1'b1;
        wait_pulse(0, 40, lat);
        check_range("rstmid_press_lat", lat, 14, 18);
        step(3);
        check("rstmid_level_before", {31'b0, pb_level[0]}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_level", {27'b0, pb_level}, 32'd0);
        check("rstmid_pulse", {27'b0, pb_pulse}, 32'd0);
        check("rstmid_any", {31'b0, pb_any}, 32'd0);
        check("rstmid_tick", {31'b0, tick}, 32'd0);
        step(3);
        rst = 1'b0;
        wait_pulse(0, 40, lat);
        check_range("rstmid_repress_lat", lat, 14, 18);
        check("rstmid_repress_lvl", {31'b0, pb_level[0]}, 32'd1);
        pb_raw[0] = 1'b0;
        wait_level(0, 1'b0, 40, lat);
        check_range("rstmid_release_lat", lat, 14, 18);

`ifdef PB_AUTOREPEAT_EN
        // Auto-repeat on channel 4: 20 cycles to first repeat, then every 8.
        pb_raw[4] = 1'b1;
        wait_pulse(4, 40, lat);
        check_range("rep_first_lat", lat, 14, 18);
        wait_pulse(4, 40, gap);
        check("rep_delay_gap", gap, 32'd20);
        wait_pulse(4, 20, gap);
        check("rep_rate_gap1", gap, 32'd8);
        wait_pulse(4, 20, gap);
        check("rep_rate_gap2", gap, 32'd8);
        pb_raw[4] = 1'b0;
        wait_level(4, 1'b0, 40, lat);
        check_range("rep_release_lat", lat, 14, 18);
        check("rep_release_no_pulse", {31'b0, pb_pulse[4]}, 32'd0);
        cnt_snap = pulse_count[4];
        step(40);
        check("rep_stopped", pulse_count[4], cnt_snap);
        check("rep_state_idle", {30'b0, dut.g_ch[4].u_ch.state_q}, {30'b0, IDLE});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within its time budget");
        $fatal(1, "timeout");
    end

endmodule
